// File: rtl/fill_dispatcher.sv
// fill_dispatcher: turns exchange fill reports into execute-order pulses for
// the inventory tracker. Fills are buffered in a FIFO, popped into a lookup
// stage (P), checked against the outstanding quoted quantity per
// {stock, side}, and loaded into an issue register (I) that emits a one-cycle
// pulse whenever the inventory block is not being read.
// Optional feature macro: FILL_DISPATCH_OVERFILL_CLIP_EN
//   defined   : applied quantity is clipped to the outstanding amount and
//               o_overfill pulses on fills larger than the outstanding amount.
//   undefined : applied quantity is the raw fill, table write-back saturates
//               at 0, o_overfill is held low.
module fill_dispatcher #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_STOCKS = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_fill_valid,
  output logic                          o_fill_ready,
  input  logic [$clog2(NUM_STOCKS)-1:0] i_fill_stock_id,
  input  logic                          i_fill_side,
  input  logic [DATA_WIDTH-1:0]         i_fill_quantity,
  input  logic                          i_quote_valid,
  input  logic [$clog2(NUM_STOCKS)-1:0] i_quote_stock_id,
  input  logic                          i_quote_side,
  input  logic [DATA_WIDTH-1:0]         i_quote_quantity,
  input  logic                          i_inv_ren,
  output logic                          o_execute_order,
  output logic                          o_execute_order_side,
  output logic [DATA_WIDTH-1:0]         o_execute_order_quantity,
  output logic [$clog2(NUM_STOCKS)-1:0] o_stock_id,
  output logic                          o_overfill,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);
  localparam int SW = $clog2(NUM_STOCKS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int NE = NUM_STOCKS * 2;

  typedef struct packed {
    logic [SW-1:0]         stock;
    logic                  side;
    logic [DATA_WIDTH-1:0] qty;
  } fill_t;

  // FIFO storage and control
  fill_t          mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           full, empty, push, pop, rdy_en;

  // pipeline registers
  logic           p_valid, iss_valid;
  fill_t          p_fill, iss_fill;

  // outstanding table and I-stage arithmetic
  logic [DATA_WIDTH-1:0] tbl [NE];
  logic [SW:0]           rd_idx, q_idx;
  logic [DATA_WIDTH-1:0] outstanding, applied, remaining;
  logic                  over, ovf, i_adv, emit;

  // last emitted fields, held while no pulse is presented
  fill_t          last_fill;
  logic           ovf_q;

  assign full         = (count == CW'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign o_fill_ready = rdy_en & i_reset_n & ~full;
  assign push         = i_fill_valid & o_fill_ready;
  assign emit         = iss_valid & ~i_inv_ren & i_reset_n;
  assign i_adv        = p_valid & (~iss_valid | emit);
  assign pop          = ~empty & (~p_valid | i_adv);
  assign rd_idx       = {p_fill.stock, p_fill.side};
  assign q_idx        = {i_quote_stock_id, i_quote_side};
  assign o_fifo_count = count;

  // ready is withheld for the first cycle after reset releases
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) rdy_en <= 1'b0;
    else            rdy_en <= 1'b1;
  end

  // FIFO payload write (data needs no reset)
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= '{stock: i_fill_stock_id, side: i_fill_side, qty: i_fill_quantity};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // P stage: FIFO head moves in whenever P is empty or handing off to I
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      p_valid <= 1'b0;
      p_fill  <= '0;
    end else if (pop) begin
      p_valid <= 1'b1;
      p_fill  <= mem[rd_ptr];
    end else if (i_adv) begin
      p_valid <= 1'b0;
    end
  end

  // I stage arithmetic on the pre-write table value
  always_comb begin
    outstanding = tbl[rd_idx];
    over        = p_fill.qty > outstanding;
    applied     = p_fill.qty;
    remaining   = '0;
    ovf         = 1'b0;
`ifdef FILL_DISPATCH_OVERFILL_CLIP_EN
    applied   = over ? outstanding : p_fill.qty;
    remaining = outstanding - applied;
    ovf       = over;
`else
    remaining = over ? '0 : (outstanding - p_fill.qty);
`endif
  end

  // issue register: loads non-zero results, clears once emitted
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      iss_valid <= 1'b0;
      iss_fill  <= '0;
    end else if (i_adv) begin
      iss_valid <= (applied != '0);
      if (applied != '0) iss_fill <= '{stock: p_fill.stock, side: p_fill.side, qty: applied};
    end else if (emit) begin
      iss_valid <= 1'b0;
    end
  end

  // overfill flag becomes visible alongside the issue register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) ovf_q <= 1'b0;
    else            ovf_q <= i_adv & ovf;
  end

  // outstanding table: quote write is ordered last so it wins a collision
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int e = 0; e < NE; e++) tbl[e] <= '0;
    end else begin
      if (i_adv)         tbl[rd_idx] <= remaining;
      if (i_quote_valid) tbl[q_idx]  <= i_quote_quantity;
    end
  end

  // remember the fields of the last pulse so outputs hold between pulses
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)  last_fill <= '0;
    else if (emit)   last_fill <= iss_fill;
  end

  assign o_execute_order          = emit;
  assign o_stock_id               = emit ? iss_fill.stock : last_fill.stock;
  assign o_execute_order_side     = emit ? iss_fill.side  : last_fill.side;
  assign o_execute_order_quantity = emit ? iss_fill.qty   : last_fill.qty;
  assign o_overfill               = ovf_q;

endmodule

// File: doc/fill_dispatcher.md
# fill_dispatcher

Converts exchange fill reports into execute-order updates for the per-stock inventory tracker, which is the consumer of those updates. Fills arrive on a valid/ready handshake and are buffered in a FIFO. Each fill is checked against the outstanding quoted quantity for its stock and side. Each resulting update is issued to the inventory block as a single-cycle pulse, held off whenever the inventory is being read.

## Interface
- `DATA_WIDTH`, 32, width of quantity fields
- `NUM_STOCKS`, 4, number of tracked stocks (power of two)
- `FIFO_DEPTH`, 8, fill buffer entries (power of two, ≥2)

- `i_clk` in 1: single clock; all logic on the rising edge
- `i_reset_n` in 1: reset, synchronous, active-low
- `i_fill_valid` in 1: a fill report is presented
- `o_fill_ready` out 1: the FIFO can accept a fill
- `i_fill_stock_id` in `$clog2(NUM_STOCKS)`: stock of the fill
- `i_fill_side` in 1: 0 = our bid filled (buy), 1 = our ask filled (sell)
- `i_fill_quantity` in `DATA_WIDTH`: filled quantity, unsigned
- `i_quote_valid` in 1: one-cycle pulse that sets the outstanding quantity
- `i_quote_stock_id` in `$clog2(NUM_STOCKS)`: quote stock
- `i_quote_side` in 1: quote side
- `i_quote_quantity` in `DATA_WIDTH`: new outstanding quantity (overwrites, does not add)
- `i_inv_ren` in 1: the inventory block is being read; the execute pulse must not fire
- `o_execute_order` out 1: one-cycle execute pulse to the inventory block
- `o_execute_order_side` out 1: side of the pulse
- `o_execute_order_quantity` out `DATA_WIDTH`: quantity applied
- `o_stock_id` out `$clog2(NUM_STOCKS)`: stock of the pulse
- `o_overfill` out 1: one-cycle pulse when a fill exceeded the outstanding quantity
- `o_fifo_count` out `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy

## Operation
- **Handshake.** A fill is accepted on any edge where `i_fill_valid & o_fill_ready` is high.
  - `o_fill_ready = !full`.
  - `o_fill_ready` is 0 while `i_reset_n` is low.
  - The producer must hold the fill fields stable while valid is high and ready is low.
- **FIFO.** Circular buffer with wrapping read and write pointers.
  - A push and a pop in the same cycle leave the count unchanged.
  - A push while full is impossible, because ready is low.
  - There is no bypass: an accepted fill is poppable from the next cycle.
- **Outstanding table.** `NUM_STOCKS`×2 unsigned entries, indexed by {stock, side}, all reset to 0.
- **Pipeline.** Two registered stages.
  - Pop stage (P): pops the FIFO head into the lookup register when the FIFO is not empty and P is empty or advancing.
  - Issue stage (I): computes `applied = min(fill_qty, outstanding)` and `remaining = outstanding - applied`, writes `remaining` back to the table, and loads the issue register.
- **Zero result.** If `applied == 0`, the issue register is not loaded and the fill is dropped.
- **Overfill.** If `fill_qty > outstanding`, `o_overfill` pulses in the same cycle the issue register would become visible. This also happens when `applied == 0`.
- **Emission and stall.**
  - `o_execute_order = issue_valid & !i_inv_ren`.
  - The issue register holds while `i_inv_ren` is high.
  - The I stage stalls while the issue register is valid and not emitting, and P stalls behind I.
  - `o_stock_id`, `o_execute_order_side` and `o_execute_order_quantity` are valid only while `o_execute_order` is high; otherwise they hold their last value.
- **Quote write vs I-stage write-back.** When both target the same entry in the same cycle, the quote write wins.
- **Quote write and I-stage read.** When a quote write hits the entry the I stage is reading in that cycle, the I stage uses the pre-write value.
- **Mid-operation reset.** Reset flushes the FIFO, both stages and the table, and no pulse is emitted in the cycle after reset.

## Timing
- Reset values, all 0: `o_execute_order`, `o_execute_order_side`, `o_execute_order_quantity`, `o_stock_id`, `o_overfill`, `o_fifo_count`, `o_fill_ready`.
- `o_fill_ready` rises 1 cycle after `i_reset_n` rises.
- Latency: a fill accepted at the edge ending cycle N gives `o_execute_order` high in cycle N+3, provided `i_inv_ren` is low and there are no stalls.
- Throughput: 1 fill per cycle sustained.
- Each cycle that `i_inv_ren` is high while the issue register is valid adds exactly 1 cycle of latency.
- `o_fifo_count` is registered and reflects pushes and pops at the preceding edge.

## Configuration
- `FILL_DISPATCH_OVERFILL_CLIP_EN` defined:
  - `applied` is clipped as described.
  - `o_overfill` is active.
- `FILL_DISPATCH_OVERFILL_CLIP_EN` undefined:
  - `applied = fill_qty` unclipped.
  - The table write-back saturates at 0.
  - `o_overfill` is tied to 0.
  - Fills with zero quantity are still dropped.

## Test plan
- **Basic fill.** Quote stock 2 side 0 qty 100; fill stock 2 side 0 qty 30 → 3 cycles later one pulse with stock 2, side 0, qty 30; outstanding becomes 70.
- **Overfill.** Quote stock 1 side 1 qty 20; fill qty 50.
  - With the macro: pulse qty 20 plus an `o_overfill` pulse; a second fill of qty 5 gives `o_overfill` and no execute pulse.
  - Without the macro: pulse qty 50 and outstanding 0.
- **Full FIFO.** Hold `i_inv_ren` high with 10 back-to-back fills → `o_fill_ready` drops when `o_fifo_count` = 8. Releasing `i_inv_ren` gives 10 consecutive pulses in order, with no loss or duplication.
- **Read stall.** `i_inv_ren` high for 4 cycles, aligned with the issue cycle → the pulse is delayed exactly 4 cycles and emitted once.
- **Quote/write-back collision.** A quote qty 500 lands on stock 3 side 0 in the same cycle the I stage writes back stock 3 side 0 → the table holds 500.
- **Mid-stream reset.** `i_reset_n` low for 1 cycle with 3 fills buffered → all outputs 0 and `o_fifo_count` = 0; no pulses afterwards.
